uart_rx: RTL and testbench
==========================

UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 The block SHALL have parameter no_clk_per_bit, default 32, giving i_clk cycles per serial bit; legal values are even integers from 4 to 256.
REQ-002 The block SHALL have port i_clk, input, 1 bit: the single clock; all state updates occur on its rising edge.
REQ-003 The block SHALL have port i_rst_n, input, 1 bit: the reset, which is asynchronous and active-low.
REQ-004 The block SHALL have port serial_data_in, input, 1 bit: the asynchronous UART line, idle high, 8N1 format, LSB first.
REQ-005 The block SHALL have port data_out, output, 8 bits: the last correctly framed received byte.
REQ-006 The block SHALL have port rx_valid, output, 1 bit: a one-cycle pulse that marks data_out as newly updated.
REQ-007 The block SHALL have port rx_active, output, 1 bit: high while a frame is being received.
REQ-008 The block SHALL have port frame_error, output, 1 bit: a one-cycle pulse when the stop bit is sampled low.

Function
REQ-009 serial_data_in SHALL pass through a two-flop synchronizer that resets to 1; all logic below uses only the synchronized value rx_s.
REQ-010 The FSM states SHALL be IDLE, START, DATA, STOP and RESYNC; any unused encoding SHALL go to IDLE on the next cycle.
REQ-011 In IDLE, clk_count and index SHALL be held at 0; when rx_s==0, the FSM SHALL move to START and set rx_active to 1 on the same edge.
REQ-012 In START, clk_count SHALL increment each cycle until clk_count==no_clk_per_bit/2-1, at which point rx_s is sampled (mid start bit).
  - If rx_s==0: clear clk_count and go to DATA.
  - If rx_s==1 (glitch): go to IDLE, clear rx_active, and pulse neither rx_valid nor frame_error.
REQ-013 In DATA, clk_count SHALL increment until clk_count==no_clk_per_bit-1, at which point the FSM:
  - stores rx_s into shift register bit [index];
  - clears clk_count;
  - increments index, or goes to STOP when index==7.
REQ-014 In STOP, on clk_count==no_clk_per_bit-1, the FSM SHALL sample rx_s and then go to RESYNC:
  - rx_s==1: load data_out from the shift register and pulse rx_valid for exactly one cycle;
  - rx_s==0: pulse frame_error for exactly one cycle and leave data_out unchanged.
REQ-015 RESYNC SHALL last one cycle; it clears rx_active and clk_count and goes to IDLE. A new frame SHALL be accepted from the following cycle.
REQ-016 rx_valid and frame_error SHALL never be high in the same cycle, and SHALL be low in every cycle other than the one specified in REQ-014.
REQ-017 data_out SHALL hold its value between valid frames.
REQ-018 clk_count SHALL be 8 bits wide and SHALL never exceed no_clk_per_bit-1; index SHALL be 3 bits wide.
REQ-019 The FSM SHALL ignore line activity during DATA and STOP other than the specified sample points.
REQ-020 Latency SHALL be fixed: rx_valid rises at 2 + no_clk_per_bit/2 + 9*no_clk_per_bit + 2 cycles (±1) after the falling start edge on serial_data_in. For no_clk_per_bit=32, this is 308 ±1 cycles.
REQ-021 The block SHALL receive correctly the output of uart_tx when both use the same no_clk_per_bit, including back-to-back frames separated by that transmitter's minimum idle gap.

Reset
REQ-022 While i_rst_n==0, the block SHALL immediately force the following values, regardless of i_clk:
  - FSM state: IDLE;
  - clk_count, index and shift register: 0;
  - synchronizer flops: 1;
  - data_out: 8'h00;
  - rx_valid, frame_error and rx_active: 0.
REQ-023 Reset asserted mid-frame SHALL abandon that frame with no rx_valid or frame_error pulse. After release, reception SHALL restart only on a fresh falling edge seen in IDLE.

Verification
REQ-024 N=32, frame 0xA5 with a valid stop bit -> one rx_valid pulse at 308 ±1 cycles, data_out=8'hA5, frame_error never high.
REQ-025 N=32, uart_tx looped back sending 0x00, 0xFF, 0x3C back-to-back -> three rx_valid pulses, with data_out equal to 00, FF and 3C in order.
REQ-026 N=32, low glitch of 10 cycles on an idle line -> rx_active high for no more than 18 cycles, then 0; no rx_valid, no frame_error.
REQ-027 N=32, 0x5A sent with the stop bit driven low -> one frame_error pulse; data_out keeps its previous value; a following good frame 0x81 -> rx_valid with data_out=8'h81.
REQ-028 i_rst_n pulsed low during data bit 4 of frame 0xC3 -> all outputs read 0 immediately; no pulse for the aborted frame; the next full frame 0x7E -> data_out=8'h7E.
REQ-029 N=4 (minimum), frame 0x96 -> rx_valid with data_out=8'h96, confirming the counter boundary conditions.

Source files
------------

// File: rtl/uart_rx.sv
// 8N1 UART receiver: two-flop synchronizer, mid-bit sampling FSM, one-cycle valid/error pulses.
// Frame timing is set by no_clk_per_bit (even, 4..256).
module uart_rx #(
    parameter int unsigned no_clk_per_bit = 32
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       serial_data_in,
    output logic [7:0] data_out,
    output logic       rx_valid,
    output logic       rx_active,
    output logic       frame_error
);

    typedef enum logic [2:0] {
        StIdle   = 3'd0,
        StStart  = 3'd1,
        StData   = 3'd2,
        StStop   = 3'd3,
        StResync = 3'd4
    } state_e;

    localparam logic [7:0] LastCnt = 8'(no_clk_per_bit - 1);
    localparam logic [7:0] HalfCnt = 8'(no_clk_per_bit / 2 - 1);

    state_e      state_q, state_d;
    logic [1:0]  sync_q;
    logic [7:0]  clk_count_q, clk_count_d;
    logic [2:0]  index_q, index_d;
    logic [7:0]  shift_q, shift_d;
    logic [7:0]  data_q, data_d;
    logic        valid_q, valid_d;
    logic        ferr_q, ferr_d;
    logic        active_q, active_d;
    logic        rx_s;
    logic        cnt_half;
    logic        cnt_last;

    assign rx_s     = sync_q[1];
    assign cnt_half = (clk_count_q == HalfCnt);
    assign cnt_last = (clk_count_q == LastCnt);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q     <= StIdle;
            sync_q      <= 2'b11;
            clk_count_q <= 8'd0;
            index_q     <= 3'd0;
            shift_q     <= 8'd0;
            data_q      <= 8'd0;
            valid_q     <= 1'b0;
            ferr_q      <= 1'b0;
            active_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            sync_q      <= {sync_q[0], serial_data_in};
            clk_count_q <= clk_count_d;
            index_q     <= index_d;
            shift_q     <= shift_d;
            data_q      <= data_d;
            valid_q     <= valid_d;
            ferr_q      <= ferr_d;
            active_q    <= active_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:   if (!rx_s) state_d = StStart;
            StStart:  if (cnt_half) state_d = rx_s ? StIdle : StData;
            StData:   if (cnt_last && index_q == 3'd7) state_d = StStop;
            StStop:   if (cnt_last) state_d = StResync;
            StResync: state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    always_comb begin
        clk_count_d = clk_count_q;
        index_d     = index_q;
        shift_d     = shift_q;
        data_d      = data_q;
        valid_d     = 1'b0;
        ferr_d      = 1'b0;
        active_d    = active_q;
        case (state_q)
            StIdle: begin
                clk_count_d = 8'd0;
                index_d     = 3'd0;
                if (!rx_s) active_d = 1'b1;
            end
            StStart: begin
                if (cnt_half) begin
                    clk_count_d = 8'd0;
                    // A high line at mid start bit was a glitch, not a frame.
                    if (rx_s) active_d = 1'b0;
                end else begin
                    clk_count_d = clk_count_q + 8'd1;
                end
            end
            StData: begin
                if (cnt_last) begin
                    shift_d[index_q] = rx_s;
                    clk_count_d      = 8'd0;
                    index_d          = index_q + 3'd1;
                end else begin
                    clk_count_d = clk_count_q + 8'd1;
                end
            end
            StStop: begin
                if (cnt_last) begin
                    clk_count_d = 8'd0;
                    if (rx_s) begin
                        data_d  = shift_q;
                        valid_d = 1'b1;
                    end else begin
                        ferr_d = 1'b1;
                    end
                end else begin
                    clk_count_d = clk_count_q + 8'd1;
                end
            end
            StResync: begin
                active_d    = 1'b0;
                clk_count_d = 8'd0;
            end
            default: begin
                active_d    = 1'b0;
                clk_count_d = 8'd0;
                index_d     = 3'd0;
            end
        endcase
    end

    assign data_out    = data_q;
    assign rx_valid    = valid_q;
    assign rx_active   = active_q;
    assign frame_error = ferr_q;

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: one instance at 32 clocks/bit, one at the 4 clocks/bit minimum.
module tb_uart_rx;

    logic       clk;
    logic       rst_n;
    logic       line32, line4;
    logic [7:0] dout32, dout4;
    logic       valid32_o, active32_o, ferr32_o;
    logic       valid4_o, active4_o, ferr4_o;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int valid32 = 0, ferr32 = 0, valid4 = 0, ferr4 = 0;
    int both_hi = 0;
    int act_cnt32 = 0;
    int valid_cyc32 = 0;
    int start_cyc = 0;
    int lat;
    logic [7:0] rx_log [0:31];

    uart_rx #(.no_clk_per_bit(32)) dut (
        .i_clk         (clk),
        .i_rst_n       (rst_n),
        .serial_data_in(line32),
        .data_out      (dout32),
        .rx_valid      (valid32_o),
        .rx_active     (active32_o),
        .frame_error   (ferr32_o)
    );

    uart_rx #(.no_clk_per_bit(4)) dut4 (
        .i_clk         (clk),
        .i_rst_n       (rst_n),
        .serial_data_in(line4),
        .data_out      (dout4),
        .rx_valid      (valid4_o),
        .rx_active     (active4_o),
        .frame_error   (ferr4_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (valid32_o) begin
            if (valid32 < 32) rx_log[valid32] = dout32;
            valid32     = valid32 + 1;
            valid_cyc32 = cyc;
        end
        if (ferr32_o) ferr32 = ferr32 + 1;
        if (valid4_o) valid4 = valid4 + 1;
        if (ferr4_o) ferr4 = ferr4 + 1;
        if ((valid32_o && ferr32_o) || (valid4_o && ferr4_o)) both_hi = both_hi + 1;
        if (active32_o) act_cnt32 = act_cnt32 + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests = n_tests + 1;
        if (got !== exp) begin
            n_fail = n_fail + 1;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic set_line(input int which, input logic v);
        if (which == 0) line32 = v;
        else line4 = v;
    endtask

    // Caller is aligned to posedge+1; each bit lasts exactly n clocks.
    task automatic send_frame(input int which, input logic [7:0] b, input logic stop_bit,
                              input int gap);
        int n;
        n = (which == 0) ? 32 : 4;
        set_line(which, 1'b0);
        start_cyc = cyc;
        tick(n);
        for (int i = 0; i < 8; i++) begin
            set_line(which, b[i]);
            tick(n);
        end
        set_line(which, stop_bit);
        tick(n);
        set_line(which, 1'b1);
        if (gap > 0) tick(gap);
    endtask

    initial begin
        logic [7:0] c3;
        c3     = 8'hC3;
        rst_n  = 1'b0;
        line32 = 1'b1;
        line4  = 1'b1;
        #2;
        check("rst_data_out", {24'd0, dout32}, 32'h0);
        check("rst_rx_valid", {31'd0, valid32_o}, 32'h0);
        check("rst_rx_active", {31'd0, active32_o}, 32'h0);
        check("rst_frame_error", {31'd0, ferr32_o}, 32'h0);
        tick(3);
        rst_n = 1'b1;
        tick(5);

        // Single frame and latency.
        send_frame(0, 8'hA5, 1'b1, 10);
        check("a5_valid_count", valid32, 1);
        check("a5_data", {24'd0, dout32}, 32'hA5);
        lat = valid_cyc32 - start_cyc;
        check("a5_latency_in_307_309", {31'd0, (lat >= 307 && lat <= 309)}, 32'h1);
        check("a5_no_ferr", ferr32, 0);

        // Back-to-back frames, only the stop bit separating them.
        send_frame(0, 8'h00, 1'b1, 0);
        send_frame(0, 8'hFF, 1'b1, 0);
        send_frame(0, 8'h3C, 1'b1, 10);
        check("b2b_valid_count", valid32, 4);
        check("b2b_byte0", {24'd0, rx_log[1]}, 32'h00);
        check("b2b_byte1", {24'd0, rx_log[2]}, 32'hFF);
        check("b2b_byte2", {24'd0, rx_log[3]}, 32'h3C);
        check("b2b_no_ferr", ferr32, 0);

        // 10-cycle glitch on idle line.
        act_cnt32 = 0;
        line32 = 1'b0;
        tick(10);
        line32 = 1'b1;
        tick(40);
        check("glitch_active_bounded", {31'd0, (act_cnt32 >= 1 && act_cnt32 <= 18)}, 32'h1);
        check("glitch_active_low", {31'd0, active32_o}, 32'h0);
        check("glitch_no_valid", valid32, 4);
        check("glitch_no_ferr", ferr32, 0);

        // Bad stop bit, then a good frame.
        send_frame(0, 8'h5A, 1'b0, 10);
        check("ferr_count", ferr32, 1);
        check("ferr_no_valid", valid32, 4);
        check("ferr_data_kept", {24'd0, dout32}, 32'h3C);
        send_frame(0, 8'h81, 1'b1, 10);
        check("after_ferr_valid", valid32, 5);
        check("after_ferr_data", {24'd0, dout32}, 32'h81);

        // Reset in the middle of data bit 4.
        line32 = 1'b0;
        tick(32);
        for (int i = 0; i < 5; i++) begin
            line32 = c3[i];
            tick((i == 4) ? 16 : 32);
        end
        #2;
        rst_n  = 1'b0;
        line32 = 1'b1;
        #1;
        check("midrst_data_out", {24'd0, dout32}, 32'h0);
        check("midrst_rx_valid", {31'd0, valid32_o}, 32'h0);
        check("midrst_rx_active", {31'd0, active32_o}, 32'h0);
        check("midrst_frame_error", {31'd0, ferr32_o}, 32'h0);
        tick(3);
        rst_n = 1'b1;
        tick(400);
        check("midrst_no_valid", valid32, 5);
        check("midrst_no_ferr", ferr32, 1);
        send_frame(0, 8'h7E, 1'b1, 10);
        check("after_rst_valid", valid32, 6);
        check("after_rst_data", {24'd0, dout32}, 32'h7E);

        // Minimum bit period.
        send_frame(1, 8'h96, 1'b1, 10);
        check("n4_valid_count", valid4, 1);
        check("n4_data", {24'd0, dout4}, 32'h96);
        check("n4_no_ferr", ferr4, 0);

        check("never_valid_and_ferr", both_hi, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
